instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameters SHALL be:
- ADDRESS_WIDTH, 32, PC/address width.
- DATA_WIDTH, 32, instruction width.
- DEPTH, 4, prefetch queue entries (power of two, >=2).
- RESET_PC, 0, first fetch address.

REQ-002 Ports SHALL be:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDRESS_WIDTH  fetch address, valid with imem_req.
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  read data valid, in request order.
- imem_rdata  in  DATA_WIDTH  returned instruction word.
- redirect  in  1  branch/jump taken, from control (PCsrc/J path).
- redirect_pc  in  ADDRESS_WIDTH  redirect target.
- instr_valid  out  1  head entry is valid.
- instr  out  DATA_WIDTH  head instruction.
- instr_pc  out  ADDRESS_WIDTH  address of head instruction.
- instr_ready  in  1  core consumes head this cycle.

Function
REQ-003 A request SHALL be accepted on a cycle with imem_req=1 and imem_ready=1; fetch_pc SHALL then advance by 4.
REQ-004 imem_req SHALL be 1 only if queue count + outstanding < DEPTH. This rule SHALL also apply while redirect=0. imem_addr SHALL equal fetch_pc.
REQ-005 Memory data SHALL be returned in order with latency >=1 cycle. Each imem_rvalid SHALL retire the oldest outstanding request.
REQ-006 A non-discarded response SHALL write {imem_rdata, its request PC} at the tail. Request PCs SHALL be held in an in-order PC FIFO of DEPTH entries.
REQ-007 instr_valid SHALL be 1 iff count != 0. instr and instr_pc SHALL be driven from the head entry.
REQ-008 A pop SHALL occur when instr_valid=1 and instr_ready=1. The head pointer SHALL wrap modulo DEPTH.
REQ-009 Simultaneous push and pop SHALL leave count unchanged. This SHALL be legal when full or empty, with no bypass: the queue is empty-to-valid in 1 cycle, and a push into an empty queue appears at the next edge.
REQ-010 On redirect=1, at the next edge:
- The queue SHALL be flushed to count 0.
- fetch_pc SHALL load {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00}.
- The discard counter SHALL load the current outstanding count, including any request accepted that same cycle.
REQ-011 During a redirect cycle, imem_req SHALL be 0. A pop in that cycle SHALL be ignored, and any response in that cycle SHALL be dropped and decrement the discard counter/outstanding count.
REQ-012 While the discard counter is non-zero, each imem_rvalid SHALL decrement it and SHALL NOT be written to the queue.
REQ-013 Back-to-back redirects SHALL each reload fetch_pc. Discards SHALL accumulate correctly: discard = outstanding at each redirect.
REQ-014 The outstanding counter and discard counter SHALL each be clog2(DEPTH)+1 bits wide and SHALL never overflow, as guaranteed by REQ-004.
REQ-015 imem_rvalid with outstanding=0 is a protocol error. It SHALL be ignored.

Reset
REQ-016 While rst=0, regardless of clk:
- fetch_pc SHALL equal RESET_PC.
- Queue, outstanding and discard counts SHALL be 0.
- imem_req, instr_valid, instr and instr_pc SHALL be 0.
REQ-017 The first request SHALL issue in the first cycle after rst deasserts, with imem_addr = RESET_PC.
REQ-018 Reset asserted mid-operation SHALL abandon all queued and outstanding state. Responses arriving after reset release for pre-reset requests are outside contract; the environment SHALL quiesce memory.

Verification
REQ-019 Steady stream: imem_ready=1, 1-cycle latency, instr_ready=1, words 0x00000013+n -> instr_pc 0,4,8,... consecutive. One instruction per cycle from cycle 2 after reset release.
REQ-020 Backpressure: instr_ready=0 for 10 cycles -> at most DEPTH=4 requests issued, imem_req=0 once count+outstanding=4, instr/instr_pc hold at 0x0/0x0.
REQ-021 Redirect with 2 outstanding: redirect=1, redirect_pc=0x00000102 -> next imem_addr=0x00000100, the 2 in-flight responses are dropped, and the first valid instr_pc=0x100.
REQ-022 Simultaneous redirect+pop+rvalid in one cycle -> count=0 next cycle, no entry popped twice, response discarded.
REQ-023 Wrap-around: alternate full/empty over 3*DEPTH instructions with random imem_ready/latency 1-3 -> instr_pc strictly +4 sequence, no loss or duplication.
REQ-024 Async reset: assert rst=0 between clock edges while full -> instr_valid=0 and imem_req=0 immediately. After release, the first imem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited, in-order prefetch queue in front of an
// instruction memory, with a redirect that flushes the queue and discards in-flight responses.
module instr_fetch_unit #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter int unsigned              DEPTH         = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ready,
  input  logic                     imem_rvalid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     instr_valid,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  input  logic                     instr_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    data;
    logic [ADDRESS_WIDTH-1:0] pc;
  } entry_t;

  entry_t                   q_mem   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_fifo [DEPTH];

  logic [ADDRESS_WIDTH-1:0] fetch_pc, fetch_pc_nxt;
  logic [PTR_W-1:0]         head, head_nxt, tail, tail_nxt;
  logic [PTR_W-1:0]         pf_head, pf_head_nxt, pf_tail, pf_tail_nxt;
  logic [CNT_W-1:0]         count, count_nxt;
  logic [CNT_W-1:0]         outstanding, outstanding_nxt;
  logic [CNT_W-1:0]         discard, discard_nxt;

  logic credit_ok, accept, resp, resp_drop, push, pop;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Queued plus in-flight words may never exceed the queue size, so every response has a slot.
  assign credit_ok = (SUM_W'(count) + SUM_W'(outstanding)) < SUM_W'(DEPTH);
  assign imem_req  = rst & ~redirect & credit_ok;
  assign imem_addr = fetch_pc;
  assign accept    = imem_req & imem_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp      = imem_rvalid & (outstanding != '0);
  assign resp_drop = resp & (redirect | (discard != '0));
  assign push      = resp & ~resp_drop;
  assign pop       = instr_valid & instr_ready & ~redirect;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? q_mem[head].data : '0;
  assign instr_pc    = instr_valid ? q_mem[head].pc   : '0;

  // Next-state for pointers, counters and fetch PC.
  always_comb begin
    fetch_pc_nxt    = fetch_pc;
    head_nxt        = head;
    tail_nxt        = tail;
    count_nxt       = count;
    pf_head_nxt     = pf_head;
    pf_tail_nxt     = pf_tail;
    outstanding_nxt = outstanding;
    discard_nxt     = discard;

    if (accept) begin
      fetch_pc_nxt = fetch_pc + ADDRESS_WIDTH'(4);
      pf_tail_nxt  = pf_tail + PTR_W'(1);
    end
    if (resp) pf_head_nxt = pf_head + PTR_W'(1);
    outstanding_nxt = outstanding + CNT_W'(accept) - CNT_W'(resp);

    if (push) tail_nxt = tail + PTR_W'(1);
    if (pop)  head_nxt = head + PTR_W'(1);
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    // Everything still in flight after this cycle belongs to the abandoned path.
    if (redirect) begin
      fetch_pc_nxt = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
      head_nxt     = '0;
      tail_nxt     = '0;
      count_nxt    = '0;
      discard_nxt  = outstanding_nxt;
    end else if (resp && (discard != '0)) begin
      discard_nxt = discard - CNT_W'(1);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      pf_head     <= '0;
      pf_tail     <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      head        <= head_nxt;
      tail        <= tail_nxt;
      count       <= count_nxt;
      pf_head     <= pf_head_nxt;
      pf_tail     <= pf_tail_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

  // Storage arrays; contents are qualified by the counters, so no reset needed.
  always_ff @(posedge clk) begin
    if (push)   q_mem[tail]      <= {imem_rdata, pc_fifo[pf_head]};
    if (accept) pc_fifo[pf_tail] <= fetch_pc;
  end

endmodule
